pll_seq_ctrl: RTL and testbench

Power-up and recovery sequencer for the system PLL that generates the DVP camera clock. It holds the PLL in reset, waits for a filtered lock with a timeout, and retries a bounded number of times. After a settle delay it gates the DVP clock output on through the PLL output enable, and it tears down and re-sequences on any loss of lock. It sits between top-level reset/enable control and the PLL wrapper's `rst_n` / `dvp_clk_en` inputs, and it consumes the PLL `lock` output.

---
 rtl/pll_seq_ctrl_if.sv | 38 +++
 rtl/pll_seq_ctrl.sv | 178 +++++++++++++++++
 tb/tb_pll_seq_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_seq_ctrl_if.sv
// pll_seq_ctrl_if: request/lock inputs and PLL control outputs
// of the DVP clock PLL sequencer.
interface pll_seq_ctrl_if #(
    parameter int MAX_RETRY = 3
);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic          req;
    logic          pll_lock;
    logic          pll_rst_n;
    logic          dvp_clk_en;
    logic          ready;
    logic          fault;
    logic          lock_lost;
    logic [RW-1:0] retry_cnt;

    modport master (
        input  req,
        input  pll_lock,
        output pll_rst_n,
        output dvp_clk_en,
        output ready,
        output fault,
        output lock_lost,
        output retry_cnt
    );

    modport slave (
        output req,
        output pll_lock,
        input  pll_rst_n,
        input  dvp_clk_en,
        input  ready,
        input  fault,
        input  lock_lost,
        input  retry_cnt
    );
endinterface

// File: rtl/pll_seq_ctrl.sv
// pll_seq_ctrl: PLL reset / lock / settle sequencer gating the
// DVP camera clock, with bounded retries and loss-of-lock recovery.
module pll_seq_ctrl #(
    parameter int RST_CYCLES    = 500,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int LOCK_FILT     = 4,
    parameter int SETTLE_CYCLES = 1000,
    parameter int MAX_RETRY     = 3
) (
    input  logic           ref_clk,
    input  logic           rst_n,
    pll_seq_ctrl_if.master bus
);
    localparam int MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ?
                             RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX = (MAX_A > SETTLE_CYCLES) ?
                             MAX_A : SETTLE_CYCLES;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam int FW = $clog2(LOCK_FILT + 1);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CW-1:0] RST_LD    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LD     = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] SET_LD    = CW'(SETTLE_CYCLES - 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILT - 1);
    localparam logic [RW-1:0] RTY_MAX   = RW'(MAX_RETRY);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RESET  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_RUN    = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd5;

    logic          sync1;
    logic          lock_s;
    logic [2:0]    st_q;
    logic [2:0]    st_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_ld;
    logic [FW-1:0] filt_q;
    logic [RW-1:0] rty_q;
    logic [RW-1:0] rty_d;
    logic          lost_d;
    logic          lock_ok;
    logic          tmo;
    logic          can_retry;
    logic          rstn_q;
    logic          run_q;
    logic          fault_q;
    logic          lost_q;

    assign lock_ok   = lock_s && (filt_q == FILT_LAST);
    assign tmo       = (cnt_q == '0);
    assign can_retry = (rty_q < RTY_MAX);

    // Two-flop synchronizer for the asynchronous PLL lock.
    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            sync1  <= bus.pll_lock;
            lock_s <= sync1;
        end
    end

    // Next state; a dropped request overrides everything else.
    always_comb begin
        st_d   = st_q;
        rty_d  = rty_q;
        lost_d = 1'b0;
        if (!bus.req) begin
            st_d = S_IDLE;
        end else begin
            case (st_q)
                S_IDLE: begin
                    st_d  = S_RESET;
                    rty_d = '0;
                end
                S_RESET: begin
                    if (tmo) st_d = S_WAIT;
                end
                S_WAIT: begin
                    if (lock_ok) begin
                        st_d = S_SETTLE;
                    end else if (tmo) begin
                        if (can_retry) begin
                            rty_d = rty_q + 1'b1;
                            st_d  = S_RESET;
                        end else begin
                            st_d = S_FAULT;
                        end
                    end
                end
                S_SETTLE: begin
                    if (!lock_s) begin
                        lost_d = 1'b1;
                        if (can_retry) begin
                            rty_d = rty_q + 1'b1;
                            st_d  = S_RESET;
                        end else begin
                            st_d = S_FAULT;
                        end
                    end else if (tmo) begin
                        st_d  = S_RUN;
                        rty_d = '0;
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        lost_d = 1'b1;
                        st_d   = S_RESET;
                        rty_d  = '0;
                    end
                end
                S_FAULT: st_d = S_FAULT;
                default: st_d = S_IDLE;
            endcase
        end
    end

    // Phase length loaded into the shared down-counter on entry.
    always_comb begin
        case (st_d)
            S_RESET:  cnt_ld = RST_LD;
            S_WAIT:   cnt_ld = TO_LD;
            S_SETTLE: cnt_ld = SET_LD;
            default:  cnt_ld = '0;
        endcase
    end

    // State, phase counter, lock filter and retry count.
    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= S_IDLE;
            cnt_q  <= '0;
            filt_q <= '0;
            rty_q  <= '0;
        end else begin
            st_q  <= st_d;
            rty_q <= rty_d;
            if (st_d != st_q) begin
                cnt_q <= cnt_ld;
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (st_q == S_WAIT && st_d == S_WAIT && lock_s) begin
                filt_q <= filt_q + 1'b1;
            end else begin
                filt_q <= '0;
            end
        end
    end

    // Registered outputs decoded from the next state.
    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            rstn_q  <= 1'b0;
            run_q   <= 1'b0;
            fault_q <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            rstn_q  <= (st_d == S_WAIT) || (st_d == S_SETTLE) ||
                       (st_d == S_RUN);
            run_q   <= (st_d == S_RUN);
            fault_q <= (st_d == S_FAULT);
            lost_q  <= lost_d;
        end
    end

    assign bus.pll_rst_n  = rstn_q;
    assign bus.dvp_clk_en = run_q;
    assign bus.ready      = run_q;
    assign bus.fault      = fault_q;
    assign bus.lock_lost  = lost_q;
    assign bus.retry_cnt  = rty_q;
endmodule

// File: tb/tb_pll_seq_ctrl.sv
// tb_pll_seq_ctrl: directed bring-up / retry / fault scenarios, then
// random req and lock activity checked against a phase-level model.
module tb_pll_seq_ctrl;
    localparam int RST  = 4;
    localparam int TOUT = 20;
    localparam int FILT = 3;
    localparam int SET  = 8;
    localparam int MR   = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    pll_seq_ctrl_if #(.MAX_RETRY(MR)) bus ();

    pll_seq_ctrl #(
        .RST_CYCLES   (RST),
        .LOCK_TIMEOUT (TOUT),
        .LOCK_FILT    (FILT),
        .SETTLE_CYCLES(SET),
        .MAX_RETRY    (MR)
    ) dut (
        .ref_clk(clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Reference model: phase, cycles spent in phase, lock run length,
    // retries, and the two most recent raw lock samples.
    typedef enum logic [2:0] {
        P_IDLE, P_RESET, P_WAIT, P_SETTLE, P_RUN, P_FAULT
    } ph_t;

    typedef struct packed {
        ph_t ph;
        int  age;
        int  run;
        int  rty;
        bit  lost;
        bit  h_old;
        bit  h_new;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t step(mdl_t c, bit rq, bit lk);
        mdl_t n;
        bit ls;
        n = c;
        ls = c.h_old;
        n.lost = 1'b0;
        n.h_old = c.h_new;
        n.h_new = lk;
        if (!rq) begin
            n.ph = P_IDLE;
        end else begin
            case (c.ph)
                P_IDLE: begin
                    n.ph = P_RESET;
                    n.rty = 0;
                end
                P_RESET: if (c.age + 1 >= RST) n.ph = P_WAIT;
                P_WAIT: begin
                    n.run = ls ? c.run + 1 : 0;
                    if (n.run >= FILT) begin
                        n.ph = P_SETTLE;
                    end else if (c.age + 1 >= TOUT) begin
                        if (c.rty < MR) begin
                            n.rty = c.rty + 1;
                            n.ph = P_RESET;
                        end else begin
                            n.ph = P_FAULT;
                        end
                    end
                end
                P_SETTLE: begin
                    if (!ls) begin
                        n.lost = 1'b1;
                        if (c.rty < MR) begin
                            n.rty = c.rty + 1;
                            n.ph = P_RESET;
                        end else begin
                            n.ph = P_FAULT;
                        end
                    end else if (c.age + 1 >= SET) begin
                        n.ph = P_RUN;
                        n.rty = 0;
                    end
                end
                P_RUN: begin
                    if (!ls) begin
                        n.lost = 1'b1;
                        n.ph = P_RESET;
                        n.rty = 0;
                    end
                end
                default: n.ph = c.ph;
            endcase
        end
        if (n.ph != c.ph) begin
            n.age = 0;
            n.run = 0;
        end else begin
            n.age = c.age + 1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else m <= step(m, bus.req, bus.pll_lock);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rstn"}, bus.pll_rst_n, 0);
        chk({tag, "_en"}, bus.dvp_clk_en, 0);
        chk({tag, "_rdy"}, bus.ready, 0);
        chk({tag, "_flt"}, bus.fault, 0);
        chk({tag, "_lost"}, bus.lock_lost, 0);
        chk({tag, "_rty"}, bus.retry_cnt, 0);
    endtask

    task automatic cmp_model();
        chk("m_rstn", bus.pll_rst_n,
            m.ph inside {P_WAIT, P_SETTLE, P_RUN});
        chk("m_en", bus.dvp_clk_en, m.ph == P_RUN);
        chk("m_rdy", bus.ready, m.ph == P_RUN);
        chk("m_flt", bus.fault, m.ph == P_FAULT);
        chk("m_lost", bus.lock_lost, m.lost);
        chk("m_rty", bus.retry_cnt, m.rty);
    endtask

    // Event log filled by watch(); k counts edges from the step start.
    int q_rise[$];
    int q_fall[$];
    int w_rdy, w_ll_n, w_ll_k, w_off, w_flt, w_r1, w_r2;

    task automatic watch(input int n, input int k0, input bit glitch,
                         input int lock_at);
        logic prst;
        logic prdy;
        q_rise.delete();
        q_fall.delete();
        w_rdy = -1; w_ll_n = 0; w_ll_k = -1; w_off = -1;
        w_flt = -1; w_r1 = -1; w_r2 = -1;
        prst = bus.pll_rst_n;
        prdy = bus.ready;
        for (int k = k0 + 1; k <= k0 + n; k++) begin
            @(negedge clk);
            if (bus.pll_rst_n && !prst) q_rise.push_back(k);
            if (!bus.pll_rst_n && prst) q_fall.push_back(k);
            if (bus.ready && !prdy && w_rdy < 0) w_rdy = k;
            if (bus.lock_lost) begin
                w_ll_n++;
                if (w_ll_k < 0) w_ll_k = k;
            end
            if (!bus.dvp_clk_en && w_off < 0) w_off = k;
            if (bus.fault && w_flt < 0) w_flt = k;
            if (bus.retry_cnt == 1 && w_r1 < 0) w_r1 = k;
            if (bus.retry_cnt == 2 && w_r2 < 0) w_r2 = k;
            prst = bus.pll_rst_n;
            prdy = bus.ready;
            if (glitch) bus.pll_lock = (k % 3) != 0;
            if (k == lock_at) bus.pll_lock = 1'b1;
        end
    endtask

    task automatic settle_idle(input logic lk);
        bus.req = 1'b0;
        @(negedge clk);
        bus.pll_lock = lk;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int seg;
        bus.req = 1'b0;
        bus.pll_lock = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1'b1;

        // nominal bring-up with lock already present
        settle_idle(1'b1);
        bus.req = 1'b1;
        watch(20, 0, 1'b0, -1);
        chk("nom_rise_n", q_rise.size(), 1);
        chk("nom_rise", q_rise[0], 1 + RST);
        chk("nom_ready", w_rdy, 1 + RST + FILT + SET);
        chk("nom_en", bus.dvp_clk_en, 1);
        chk("nom_rty", bus.retry_cnt, 0);

        // one-cycle lock drop in RUN
        bus.pll_lock = 1'b0;
        @(negedge clk);
        chk("ll_k1_lost", bus.lock_lost, 0);
        bus.pll_lock = 1'b1;
        watch(22, 1, 1'b0, -1);
        chk("ll_at", w_ll_k, 3);
        chk("ll_once", w_ll_n, 1);
        chk("ll_en_off", w_off, 3);
        chk("ll_fall", q_fall.size() == 1 ? q_fall[0] : -1, 3);
        chk("ll_rise", q_rise.size() == 1 ? q_rise[0] : -1, 3 + RST);
        chk("ll_ready", w_rdy, 3 + RST + FILT + SET);
        chk("ll_rty", bus.retry_cnt, 0);

        // req low in RUN
        bus.req = 1'b0;
        @(negedge clk);
        chk("rql_rdy", bus.ready, 0);
        chk("rql_en", bus.dvp_clk_en, 0);
        chk("rql_rstn", bus.pll_rst_n, 0);

        // timeout to fault with no lock
        bus.pll_lock = 1'b0;
        repeat (3) @(negedge clk);
        bus.req = 1'b1;
        watch(80, 0, 1'b0, -1);
        chk("to_rise_n", q_rise.size(), 3);
        chk("to_fall_n", q_fall.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("to_rise", q_rise[i], 5 + 24 * i);
            chk("to_fall", q_fall[i], 25 + 24 * i);
        end
        chk("to_r1", w_r1, 25);
        chk("to_r2", w_r2, 49);
        chk("to_fault", w_flt, 73);
        chk("to_rstn", bus.pll_rst_n, 0);
        bus.req = 1'b0;
        @(negedge clk);
        chk("to_clr_flt", bus.fault, 0);
        chk("to_clr_rstn", bus.pll_rst_n, 0);
        chk("to_clr_rty", bus.retry_cnt, 2);

        // glitchy lock never passes the filter
        settle_idle(1'b0);
        bus.req = 1'b1;
        watch(80, 0, 1'b1, -1);
        chk("gl_r1", w_r1, 25);
        chk("gl_r2", w_r2, 49);
        chk("gl_fault", w_flt, 73);
        chk("gl_noready", w_rdy, -1);

        // 3rd filtered lock cycle coincides with the timeout
        settle_idle(1'b0);
        bus.req = 1'b1;
        watch(40, 0, 1'b0, 20);
        chk("sim_r1", w_r1, -1);
        chk("sim_ready", w_rdy, 25 + SET);
        chk("sim_noflt", w_flt, -1);
        chk("sim_rty", bus.retry_cnt, 0);

        // req drop coinciding with the second timeout
        settle_idle(1'b0);
        bus.req = 1'b1;
        repeat (48) @(negedge clk);
        chk("rqt_pre", bus.retry_cnt, 1);
        bus.req = 1'b0;
        @(negedge clk);
        chk("rqt_rty", bus.retry_cnt, 1);
        chk("rqt_rstn", bus.pll_rst_n, 0);
        chk("rqt_flt", bus.fault, 0);
        repeat (3) @(negedge clk);
        chk("rqt_hold", bus.retry_cnt, 1);
        bus.req = 1'b1;
        @(negedge clk);
        chk("rqt_new", bus.retry_cnt, 0);

        // async reset in SETTLE
        settle_idle(1'b1);
        bus.req = 1'b1;
        repeat (10) @(negedge clk);
        chk("ar_settle_rstn", bus.pll_rst_n, 1);
        chk("ar_settle_rdy", bus.ready, 0);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("ar");
        @(negedge clk);
        rst_n = 1'b1;
        watch(20, 0, 1'b0, -1);
        chk("ar_rise", q_rise.size() == 1 ? q_rise[0] : -1, 1 + RST);
        chk("ar_ready", w_rdy, 1 + RST + FILT + SET);

        // random req / lock activity against the model
        seg = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            cmp_model();
            if (seg == 0) begin
                bus.pll_lock = ~bus.pll_lock;
                seg = bus.pll_lock ? $urandom_range(1, 40)
                                   : $urandom_range(1, 50);
            end else begin
                seg--;
            end
            if (bus.req) begin
                if ($urandom_range(0, 149) == 0) bus.req = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                bus.req = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
